// File: rtl/core_fetch_unit.sv
// -----------------------------------------------------------------------------
// core_fetch_unit
//
// Instruction fetch stage. Owns the program counter, issues at most one
// outstanding request on the instruction-memory req/gnt/rvalid interface and
// hands each fetched word plus its PC to decode over a valid/ready handshake.
//
// Optional build macro: FETCH_PERF_CNT_EN
//   When defined, adds two free-running 32-bit performance counters:
//   stall_cycles (cycles spent idle because of fetch_stall) and
//   fetched_count (instruction handshakes with decode).
//
// Ports:
//   clk            core clock, everything on the rising edge
//   rst            synchronous reset, active-high
//   fetch_stall    blocks launching a new fetch (in-flight fetches complete)
//   new_pc         redirect target (low two bits ignored)
//   new_pc_valid   one-cycle redirect strobe, highest priority
//   imem_req       request to instruction memory (high while in REQ)
//   imem_addr      request address, word aligned, equals the current PC
//   imem_gnt       memory accepted the request this cycle
//   imem_rvalid    response word valid
//   imem_rdata     response word
//   instr          fetched instruction towards decode
//   instr_pc       PC of instr
//   instr_valid    instr / instr_pc valid
//   instr_ready    decode accepts instr
//   stall_cycles   (FETCH_PERF_CNT_EN only) idle-and-stalled cycle count
//   fetched_count  (FETCH_PERF_CNT_EN only) decode handshake count
// -----------------------------------------------------------------------------
module core_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_stall,
    input  logic [XLEN-1:0] new_pc,
    input  logic            new_pc_valid,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     fetched_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

    state_t          state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    // Redirect target captured while a request is still waiting for grant;
    // the PC (and therefore imem_addr) must not move until the grant.
    logic [XLEN-1:0] pend_pc_reg, pend_pc_next;
    logic            pend_valid_reg, pend_valid_next;
    // Set when the response of the in-flight request belongs to a stale path.
    logic            discard_reg, discard_next;
    logic [XLEN-1:0] instr_reg, instr_next;
    logic [XLEN-1:0] instr_pc_reg, instr_pc_next;
    logic            instr_valid_reg, instr_valid_next;

    logic [XLEN-1:0] redirect_pc;

    assign redirect_pc = new_pc & ALIGN_MASK;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            pc_reg          <= RESET_PC & ALIGN_MASK;
            pend_pc_reg     <= '0;
            pend_valid_reg  <= 1'b0;
            discard_reg     <= 1'b0;
            instr_reg       <= '0;
            instr_pc_reg    <= '0;
            instr_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            pend_pc_reg     <= pend_pc_next;
            pend_valid_reg  <= pend_valid_next;
            discard_reg     <= discard_next;
            instr_reg       <= instr_next;
            instr_pc_reg    <= instr_pc_next;
            instr_valid_reg <= instr_valid_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        pend_pc_next     = pend_pc_reg;
        pend_valid_next  = pend_valid_reg;
        discard_next     = discard_reg;
        instr_next       = instr_reg;
        instr_pc_next    = instr_pc_reg;
        instr_valid_next = instr_valid_reg;

        case (state_reg)
            IDLE: begin
                if (new_pc_valid) begin
                    pc_next = redirect_pc;
                end else if (!fetch_stall) begin
                    state_next = REQ;
                end
            end

            REQ: begin
                if (imem_gnt) begin
                    state_next      = WAIT;
                    pend_valid_next = 1'b0;
                    // The address already went out, so the PC may move now:
                    // a same-cycle redirect wins over an older pending one.
                    if (new_pc_valid) begin
                        pc_next      = redirect_pc;
                        discard_next = 1'b1;
                    end else if (pend_valid_reg) begin
                        pc_next = pend_pc_reg;
                    end
                end else if (new_pc_valid) begin
                    pend_pc_next    = redirect_pc;
                    pend_valid_next = 1'b1;
                    discard_next    = 1'b1;
                end
            end

            WAIT: begin
                if (new_pc_valid) begin
                    pc_next = redirect_pc;
                    if (imem_rvalid) begin
                        // Response and redirect together: response is dropped.
                        state_next   = IDLE;
                        discard_next = 1'b0;
                    end else begin
                        discard_next = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (discard_reg) begin
                        state_next   = IDLE;
                        discard_next = 1'b0;
                    end else begin
                        state_next       = OUT;
                        instr_next       = imem_rdata;
                        instr_pc_next    = pc_reg;
                        pc_next          = pc_reg + XLEN'(4);
                        instr_valid_next = 1'b1;
                    end
                end
            end

            OUT: begin
                if (new_pc_valid) begin
                    // Held instruction is on the wrong path; drop it.
                    instr_valid_next = 1'b0;
                    pc_next          = redirect_pc;
                    state_next       = IDLE;
                end else if (instr_ready) begin
                    instr_valid_next = 1'b0;
                    state_next       = fetch_stall ? IDLE : REQ;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign imem_req    = (state_reg == REQ);
    assign imem_addr   = pc_reg;
    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;
    assign instr_valid = instr_valid_reg;

`ifdef FETCH_PERF_CNT_EN
    // -------------------------------------------------------------------------
    // Performance counters (wrap naturally at 2^32)
    // -------------------------------------------------------------------------
    logic [31:0] stall_cycles_reg;
    logic [31:0] fetched_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_reg  <= '0;
            fetched_count_reg <= '0;
        end else begin
            if ((state_reg == IDLE) && fetch_stall && !new_pc_valid) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
            if (instr_valid_reg && instr_ready) begin
                fetched_count_reg <= fetched_count_reg + 32'd1;
            end
        end
    end

    assign stall_cycles  = stall_cycles_reg;
    assign fetched_count = fetched_count_reg;
`endif

endmodule

// File: tb/tb_core_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_core_fetch_unit
//
// Directed scenarios followed by a randomized run. A transaction-level model
// tracks the architectural next-fetch PC, which granted request is live or
// stale, and the queue of instructions decode must see; a small memory model
// answers grants after a random latency with a word derived from the address.
// -----------------------------------------------------------------------------
module tb_core_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_stall;
    logic [31:0] new_pc;
    logic        new_pc_valid;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] fetched_count;
    logic [31:0] exp_stall;
    logic [31:0] exp_fetched;
`endif

    always #5 clk = ~clk;

    core_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_stall  (fetch_stall),
        .new_pc       (new_pc),
        .new_pc_valid (new_pc_valid),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles  (stall_cycles),
        .fetched_count (fetched_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } fetch_t;

    // reference model
    fetch_t      exp_q[$];
    logic [31:0] exp_pc;
    bit          live;
    bit          stale;
    logic [31:0] stale_addr;
    int          delivered;

    // memory model
    bit          mem_busy;
    int          mem_delay;
    logic [31:0] mem_addr;

    // stimulus knobs for the next cycle
    bit          k_stall, k_redir, k_ready, k_gnt, k_spur;
    logic [31:0] k_target;
    int          k_lat;

    // what happened in the previous cycle
    bit          have_prev, p_idle, p_stall, p_redir, p_ready, p_valid, p_req, p_gnt;
    logic [31:0] p_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs_v, exp_v);
        end
    endtask

    // Sample outputs on the falling edge and compare with the model.
    task automatic obs();
        bit exp_req;
        @(negedge clk);
        chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        if (have_prev) begin
            exp_req = (p_idle && !p_stall && !p_redir) ||
                      (p_valid && p_ready && !p_stall && !p_redir) ||
                      (p_req && !p_gnt);
            chk("imem_req", 32'(imem_req), 32'(exp_req));
            if (p_req && !p_gnt && imem_req)
                chk("addr_stable", imem_addr, p_addr);
        end
        chk("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0 && instr_valid) begin
            chk("instr", instr, exp_q[0].word);
            chk("instr_pc", instr_pc, exp_q[0].pc);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, exp_stall);
        chk("fetched_count", fetched_count, exp_fetched);
`endif
    endtask

    // Drive inputs for the coming rising edge and advance the model.
    task automatic drv();
        bit          cur_busy, resp, grant, hs, idle_now;
        logic [31:0] resp_addr;
        fetch_stall  = k_stall;
        new_pc_valid = k_redir;
        new_pc       = k_target;
        instr_ready  = k_ready;
        cur_busy     = mem_busy;
        resp         = 1'b0;
        resp_addr    = '0;
        imem_rvalid  = 1'b0;
        imem_rdata   = $urandom;
        if (mem_busy) begin
            mem_delay--;
            if (mem_delay == 0) begin
                resp        = 1'b1;
                resp_addr   = mem_addr;
                mem_busy    = 1'b0;
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr);
            end
        end else if (k_spur) begin
            imem_rvalid = 1'b1;     // stray response, must be ignored
        end
        imem_gnt = k_gnt && imem_req;
        grant    = imem_req && imem_gnt;
        idle_now = !imem_req && !instr_valid && !cur_busy;
        hs       = instr_valid && instr_ready;

        if (hs && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            delivered++;
        end
        if (resp && live) begin
            exp_q.push_back('{word: mem_word(resp_addr), pc: resp_addr});
            exp_pc = resp_addr + 32'd4;
            live   = 1'b0;
        end
        if (grant) begin
            if (stale) begin
                chk("stale_gnt_addr", imem_addr, stale_addr);
                stale = 1'b0;
                live  = 1'b0;
            end else begin
                chk("gnt_addr", imem_addr, exp_pc);
                live = 1'b1;
            end
            mem_busy  = 1'b1;
            mem_delay = k_lat;
            mem_addr  = imem_addr;
        end
        if (k_redir) begin
            exp_q.delete();
            live   = 1'b0;
            exp_pc = k_target & 32'hFFFF_FFFC;
            if (imem_req && !imem_gnt && !stale) begin
                stale      = 1'b1;
                stale_addr = imem_addr;
            end
        end
`ifdef FETCH_PERF_CNT_EN
        if (idle_now && k_stall && !k_redir) exp_stall++;
        if (hs) exp_fetched++;
`endif
        have_prev = 1'b1;
        p_idle    = idle_now;
        p_stall   = k_stall;
        p_redir   = k_redir;
        p_ready   = k_ready;
        p_valid   = instr_valid;
        p_req     = imem_req;
        p_gnt     = imem_gnt;
        p_addr    = imem_addr;
    endtask

    task automatic step();
        obs();
        drv();
    endtask

    task automatic do_reset(input bit stall_at_release);
        @(negedge clk);
        rst          = 1'b1;
        fetch_stall  = 1'b0;
        new_pc_valid = 1'b0;
        new_pc       = '0;
        imem_gnt     = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = '0;
        instr_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_imem_addr", imem_addr, RST_PC);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_stall_cycles", stall_cycles, 32'd0);
        chk("rst_fetched_count", fetched_count, 32'd0);
        exp_stall   = stall_at_release ? 32'd1 : 32'd0;
        exp_fetched = 32'd0;
`endif
        rst         = 1'b0;
        fetch_stall = stall_at_release;
        exp_q.delete();
        exp_pc    = RST_PC;
        live      = 1'b0;
        stale     = 1'b0;
        mem_busy  = 1'b0;
        have_prev = 1'b1;
        p_idle    = 1'b1;
        p_stall   = stall_at_release;
        p_redir   = 1'b0;
        p_ready   = 1'b0;
        p_valid   = 1'b0;
        p_req     = 1'b0;
        p_gnt     = 1'b0;
        p_addr    = RST_PC;
    endtask

    initial begin
        logic [31:0] got [3];
        logic [31:0] held_instr, held_pc;
        int          n, first_i;
        bit          found, seen_valid;

        rst = 1'b1;
        delivered = 0;
        k_stall = 1'b1; k_redir = 1'b0; k_target = '0; k_ready = 1'b1;
        k_gnt = 1'b1; k_lat = 1; k_spur = 1'b0;

        // ---- stall held in IDLE, then three sequential fetches ----
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            obs(); chk("stall_no_req", 32'(imem_req), 32'd0); drv();
        end
        obs(); chk("stall_no_req", 32'(imem_req), 32'd0);
        k_stall = 1'b0; drv();
        obs(); chk("req_after_stall", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, RST_PC); drv();
        n = 0; first_i = -1;
        for (int i = 0; i < 30 && n < 3; i++) begin
            obs();
            if (instr_valid) begin
                if (first_i < 0) first_i = i;
                got[n] = instr_pc;
                n++;
            end
            drv();
        end
        chk("seq_count", 32'(n), 32'd3);
        chk("first_valid_latency", 32'(first_i), 32'd1);
        chk("seq_pc0", got[0], 32'h100);
        chk("seq_pc1", got[1], 32'h104);
        chk("seq_pc2", got[2], 32'h108);

        // ---- redirect while waiting for the response ----
        obs();
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall_5", stall_cycles, 32'd5);
        chk("perf_fetched_3", fetched_count, 32'd3);
`endif
        chk("next_addr", imem_addr, 32'h10C);
        k_lat = 3; drv();
        obs(); k_redir = 1'b1; k_target = 32'h200; drv();
        k_redir = 1'b0; k_lat = 1;
        found = 1'b0; seen_valid = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            obs();
            if (instr_valid) seen_valid = 1'b1;
            if (imem_req) begin
                found = 1'b1;
                chk("wait_redir_addr", imem_addr, 32'h200);
            end
            drv();
        end
        chk("wait_redir_found", 32'(found), 32'd1);
        chk("wait_redir_dropped", 32'(seen_valid), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            obs();
            if (instr_valid) begin
                found = 1'b1;
                chk("wait_redir_pc", instr_pc, 32'h200);
            end
            drv();
        end
        chk("wait_redir_valid", 32'(found), 32'd1);

        // ---- grant withheld, redirect in first REQ cycle ----
        obs(); chk("req_204", 32'(imem_req), 32'd1); chk("addr_204", imem_addr, 32'h204);
        k_gnt = 1'b0; k_redir = 1'b1; k_target = 32'h300; drv();
        k_redir = 1'b0;
        for (int i = 0; i < 2; i++) begin
            obs(); chk("held_req", 32'(imem_req), 32'd1); chk("held_addr", imem_addr, 32'h204); drv();
        end
        obs(); chk("held_addr", imem_addr, 32'h204);
        k_gnt = 1'b1; drv();
        found = 1'b0; seen_valid = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            obs();
            if (instr_valid) seen_valid = 1'b1;
            if (imem_req) begin
                found = 1'b1;
                chk("req_redir_addr", imem_addr, 32'h300);
            end
            drv();
        end
        chk("req_redir_found", 32'(found), 32'd1);
        chk("req_redir_dropped", 32'(seen_valid), 32'd0);

        // ---- decode back-pressure for four cycles ----
        found = 1'b0; held_instr = '0; held_pc = '0;
        for (int i = 0; i < 20 && !found; i++) begin
            obs();
            if (instr_valid) begin
                found = 1'b1;
                chk("req_redir_pc", instr_pc, 32'h300);
                held_instr = instr;
                held_pc    = instr_pc;
                k_ready    = 1'b0;
            end
            drv();
        end
        chk("req_redir_valid", 32'(found), 32'd1);
        for (int i = 0; i < 3; i++) begin
            obs();
            chk("bp_valid", 32'(instr_valid), 32'd1);
            chk("bp_instr", instr, held_instr);
            chk("bp_pc", instr_pc, held_pc);
            chk("bp_no_req", 32'(imem_req), 32'd0);
            drv();
        end
        obs(); chk("bp_instr", instr, held_instr);
        k_ready = 1'b1; drv();
        obs(); chk("bp_req_after", 32'(imem_req), 32'd1); chk("bp_addr_after", imem_addr, 32'h304);

        // ---- PC wrap at the top of the address space ----
        k_redir = 1'b1; k_target = 32'hFFFF_FFFC; drv();
        k_redir = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            obs();
            if (instr_valid) begin
                found = 1'b1;
                chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
            end
            drv();
        end
        chk("wrap_valid", 32'(found), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            obs();
            if (imem_req) begin
                found = 1'b1;
                chk("wrap_addr", imem_addr, 32'h0);
            end
            drv();
        end
        chk("wrap_req", 32'(found), 32'd1);

        // ---- randomized traffic, with a reset dropped in the middle ----
        delivered = 0;
        for (int i = 0; i < 3000; i++) begin
            k_stall = ($urandom_range(0, 3) == 0);
            k_redir = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       k_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                1:       k_target = 32'($urandom_range(0, 255));
                default: k_target = $urandom;
            endcase
            k_ready = ($urandom_range(0, 9) < 7);
            k_gnt   = ($urandom_range(0, 9) < 6);
            k_lat   = $urandom_range(1, 3);
            k_spur  = ($urandom_range(0, 9) == 0);
            if (i == 1500) do_reset(1'b0);
            else           step();
        end
        chk("random_progress", 32'(delivered > 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
